// File: rtl/arb_cnt_sched.sv
// arb_cnt_sched: two-requester round-robin arbiter that owns a shared MIN..MAX run counter
module arb_cnt_sched #(
   parameter logic [7:0] MIN_VALUE = 8'd10,
   parameter logic [7:0] MAX_VALUE = 8'd13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic [7:0] out,
   output logic       busy,
   output logic [1:0] done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic ptr, ptr_n;
   logic [1:0] gnt_n, done_n, sel;
   logic [7:0] out_n;
   logic busy_n;
   // ptr high favours requester 1 when both request
   assign sel = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out   <= MIN_VALUE;
         gnt   <= 2'b00;
         busy  <= 1'b0;
         done  <= 2'b00;
         ptr   <= 1'b0;
      end else begin
         state <= nxt;
         out   <= out_n;
         gnt   <= gnt_n;
         busy  <= busy_n;
         done  <= done_n;
         ptr   <= ptr_n;
      end
   end
   // next state and next output values; a run ends (done or abort) by pointing at the other requester
   always_comb begin
      nxt    = state;
      out_n  = out;
      gnt_n  = gnt;
      busy_n = busy;
      done_n = 2'b00;
      ptr_n  = ptr;
      case (state)
         IDLE: begin
            out_n  = MIN_VALUE;
            gnt_n  = sel;
            busy_n = |req;
            nxt    = (|req) ? RUN : IDLE;
         end
         RUN: begin
            if (!(|(req & gnt))) begin
               nxt    = IDLE;
               out_n  = MIN_VALUE;
               gnt_n  = 2'b00;
               busy_n = 1'b0;
               ptr_n  = gnt[0];
            end else if (out == MAX_VALUE) begin
               nxt    = DONE;
               gnt_n  = 2'b00;
               busy_n = 1'b0;
               done_n = gnt;
               ptr_n  = gnt[0];
            end else begin
               out_n = out + 8'd1;
            end
         end
         DONE: begin
            nxt   = IDLE;
            out_n = MIN_VALUE;
         end
         default: nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_arb_cnt_sched.sv
// tb_arb_cnt_sched: table-driven scoreboard bench for arb_cnt_sched plus degenerate-range sequence
module tb_arb_cnt_sched;
   logic clk = 1'b0;
   logic rst, rst2;
   logic [1:0] req, req2;
   logic [1:0] gnt, gnt2, done, done2;
   logic [7:0] out, out2;
   logic busy, busy2;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       r;
      logic [1:0] q;
      logic [1:0] g;
      logic [7:0] o;
      logic       b;
      logic [1:0] d;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   arb_cnt_sched dut (.clk(clk), .rst(rst), .req(req), .gnt(gnt), .out(out), .busy(busy), .done(done));
   arb_cnt_sched #(.MIN_VALUE(8'd5), .MAX_VALUE(8'd5)) dut2 (.clk(clk), .rst(rst2), .req(req2), .gnt(gnt2), .out(out2), .busy(busy2), .done(done2));

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [1:0] q, input logic [1:0] g, input logic [7:0] o, input logic b, input logic [1:0] d);
      vec_t v;
      v.r = r; v.q = q; v.g = g; v.o = o; v.b = b; v.d = d;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got gnt/out/busy/done=%h want %h", name, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      // single request run
      add(1, 2'b00, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b01, 2'b01, 8'd10, 1, 2'b00);
      add(0, 2'b01, 2'b01, 8'd11, 1, 2'b00);
      add(0, 2'b01, 2'b01, 8'd12, 1, 2'b00);
      add(0, 2'b01, 2'b01, 8'd13, 1, 2'b00);
      add(0, 2'b01, 2'b00, 8'd13, 0, 2'b01);
      add(0, 2'b00, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b00, 2'b00, 8'd10, 0, 2'b00);
      // contention from reset: 0, then 1, then 0, with 2-cycle gaps
      add(1, 2'b11, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b11, 2'b01, 8'd10, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd11, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd12, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd13, 1, 2'b00);
      add(0, 2'b11, 2'b00, 8'd13, 0, 2'b01);
      add(0, 2'b11, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b11, 2'b10, 8'd10, 1, 2'b00);
      add(0, 2'b11, 2'b10, 8'd11, 1, 2'b00);
      add(0, 2'b11, 2'b10, 8'd12, 1, 2'b00);
      add(0, 2'b11, 2'b10, 8'd13, 1, 2'b00);
      add(0, 2'b11, 2'b00, 8'd13, 0, 2'b10);
      add(0, 2'b11, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b11, 2'b01, 8'd10, 1, 2'b00);
      add(0, 2'b00, 2'b00, 8'd10, 0, 2'b00);
      // abort of requester 1 after out=11, then contention favours 0
      add(0, 2'b10, 2'b10, 8'd10, 1, 2'b00);
      add(0, 2'b10, 2'b10, 8'd11, 1, 2'b00);
      add(0, 2'b01, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b11, 2'b01, 8'd10, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd11, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd12, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd13, 1, 2'b00);
      add(0, 2'b11, 2'b00, 8'd13, 0, 2'b01);
      add(0, 2'b00, 2'b00, 8'd10, 0, 2'b00);
      // reset while out=12 restores pointer to requester 0
      add(0, 2'b10, 2'b10, 8'd10, 1, 2'b00);
      add(0, 2'b10, 2'b10, 8'd11, 1, 2'b00);
      add(0, 2'b10, 2'b10, 8'd12, 1, 2'b00);
      add(1, 2'b10, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b11, 2'b01, 8'd10, 1, 2'b00);
      // non-owner toggling during requester 0's run
      add(0, 2'b11, 2'b01, 8'd11, 1, 2'b00);
      add(0, 2'b01, 2'b01, 8'd12, 1, 2'b00);
      add(0, 2'b11, 2'b01, 8'd13, 1, 2'b00);
      add(0, 2'b01, 2'b00, 8'd13, 0, 2'b01);
      add(0, 2'b11, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b11, 2'b10, 8'd10, 1, 2'b00);
      add(0, 2'b00, 2'b00, 8'd10, 0, 2'b00);
      add(0, 2'b00, 2'b00, 8'd10, 0, 2'b00);

      rst = 1'b1; req = 2'b00; rst2 = 1'b1; req2 = 2'b00;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst = vecs[i].r;
         req = vecs[i].q;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("vec%0d", i), {gnt, out, busy, done}, {e.g, e.o, e.b, e.d});
      end

      // degenerate range MIN=MAX=5
      @(negedge clk); rst2 = 1'b0; req2 = 2'b01;
      @(posedge clk); #1;
      chk("deg_run", {gnt2, out2, busy2, done2}, {2'b01, 8'd5, 1'b1, 2'b00});
      @(posedge clk); #1;
      chk("deg_done", {gnt2, out2, busy2, done2}, {2'b00, 8'd5, 1'b0, 2'b01});
      @(negedge clk); req2 = 2'b00;
      @(posedge clk); #1;
      chk("deg_idle", {gnt2, out2, busy2, done2}, {2'b00, 8'd5, 1'b0, 2'b00});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
